// File: rtl/uart_mem_loader_if.sv
// Bundle of the UART line and memory-write side of uart_mem_loader.
// The loader drives everything through the master modport except uart_rx.
interface uart_mem_loader_if;
    logic        uart_rx;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        frame_err;
    logic        cksum_err;

    modport master (
        input  uart_rx,
        output wr_en, wr_addr, wr_data, busy, done, frame_err, cksum_err
    );

    modport slave (
        output uart_rx,
        input  wr_en, wr_addr, wr_data, busy, done, frame_err, cksum_err
    );
endinterface

// File: rtl/uart_mem_loader.sv
// UART (8N1) receiver that packs bytes MSB-first into 32-bit words and writes them to addresses 0x00..0xFF.
// Optional per-word checksum byte is enabled by defining LOADER_CKSUM_EN.
module uart_mem_loader #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_mem_loader_if.master  io_bus
);
    localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD;
    localparam int HALF_BIT       = CLKS_PER_BIT / 2;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W          = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

`ifdef LOADER_CKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
    localparam int         WORD_W    = 32;

    function automatic logic [7:0] cksum8(input logic [31:0] w);
        return w[31:24] + w[23:16] + w[15:8] + w[7:0];
    endfunction
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
    localparam int         WORD_W    = 24;
`endif

    logic              r_rx_meta;
    logic              r_rx_sync;
    logic              r_rx_prev;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_rx_byte;
    logic [2:0]        r_byte_cnt;
    logic [WORD_W-1:0] r_word;
    logic [TO_W-1:0]   r_idle_cnt;
    logic              r_wr_en;
    logic [7:0]        r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_done;
    logic              r_frame_err;
    logic              r_cksum_err;

    logic w_fall;
    logic w_sample;
    logic w_stop_ok;
    logic w_stop_bad;
    logic w_timeout;

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_sample   = (r_clk_cnt == {CNT_W{1'b0}});
    assign w_stop_ok  = (r_state == S_STOP) & w_sample &  r_rx_sync;
    assign w_stop_bad = (r_state == S_STOP) & w_sample & ~r_rx_sync;
    assign w_timeout  = (r_state == S_IDLE) && (r_byte_cnt != 3'd0) &&
                        (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= io_bus.uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Receive FSM: counts down to each sample point and shifts data in LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= {CNT_W{1'b0}};
            r_bit_idx <= 3'd0;
            r_rx_byte <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state   <= S_START;
                        r_clk_cnt <= CNT_W'(HALF_BIT);
                    end
                end
                S_START: begin
                    if (!w_sample) begin
                        r_clk_cnt <= r_clk_cnt - CNT_W'(1);
                    end else if (!r_rx_sync) begin
                        r_state   <= S_DATA;
                        r_clk_cnt <= CNT_W'(CLKS_PER_BIT - 1);
                        r_bit_idx <= 3'd0;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!w_sample) begin
                        r_clk_cnt <= r_clk_cnt - CNT_W'(1);
                    end else begin
                        r_rx_byte <= {r_rx_sync, r_rx_byte[7:1]};
                        r_clk_cnt <= CNT_W'(CLKS_PER_BIT - 1);
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    // Back to IDLE on the stop sample itself, good or bad.
                    if (w_sample) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Idle-gap counter for discarding a partially assembled word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= {TO_W{1'b0}};
        end else if ((r_state != S_IDLE) || (r_byte_cnt == 3'd0) || w_timeout) begin
            r_idle_cnt <= {TO_W{1'b0}};
        end else begin
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end
    end

    // Word assembly, write strobe, address sequencing and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt  <= 3'd0;
            r_word      <= {WORD_W{1'b0}};
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 8'd0;
            r_wr_data   <= 32'd0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_cksum_err <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_frame_err <= 1'b0;
            r_cksum_err <= 1'b0;

            // The write to 0xFF wraps the address and locks out further writes.
            if (r_wr_en) begin
                r_wr_addr <= r_wr_addr + 8'd1;
                if (r_wr_addr == 8'hFF) begin
                    r_done <= 1'b1;
                end
            end

            if (w_timeout) begin
                r_byte_cnt <= 3'd0;
            end else if (w_stop_bad) begin
                r_frame_err <= 1'b1;
                r_byte_cnt  <= 3'd0;
            end else if (w_stop_ok) begin
                if (r_byte_cnt == LAST_BYTE) begin
                    r_byte_cnt <= 3'd0;
`ifdef LOADER_CKSUM_EN
                    if (r_rx_byte != cksum8(r_word)) begin
                        r_cksum_err <= 1'b1;
                    end else if (!r_done) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= r_word;
                    end
`else
                    if (!r_done) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= {r_word, r_rx_byte};
                    end
`endif
                end else begin
                    r_word     <= {r_word[WORD_W-9:0], r_rx_byte};
                    r_byte_cnt <= r_byte_cnt + 3'd1;
                end
            end
        end
    end

    assign io_bus.wr_en     = r_wr_en;
    assign io_bus.wr_addr   = r_wr_addr;
    assign io_bus.wr_data   = r_wr_data;
    assign io_bus.done      = r_done;
    assign io_bus.frame_err = r_frame_err;
    assign io_bus.cksum_err = r_cksum_err;
    assign io_bus.busy      = (r_state != S_IDLE) || (r_byte_cnt != 3'd0);

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed + randomized bench for uart_mem_loader; expected writes come from an address/done model and a queue.
// Bit rate is 5 clocks/bit so that a full 256-word fill stays short.
module tb_uart_mem_loader;
    localparam int CLK_FREQ     = 1_000_000;
    localparam int BAUD         = 200_000;
    localparam int CPB          = CLK_FREQ / BAUD;
    localparam int TIMEOUT_BITS = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_mem_loader_if bus ();

    uart_mem_loader #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int n_ferr = 0;
    int n_cerr = 0;
    logic [39:0] obs_q[$];
    logic [39:0] exp_q[$];
    int m_addr = 0;
    bit m_done = 1'b0;

    // Capture every write strobe and error pulse between clock edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en)     obs_q.push_back({bus.wr_addr, bus.wr_data});
            if (bus.frame_err) n_ferr++;
            if (bus.cksum_err) n_cerr++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bus.uart_rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            wait_clks(CPB);
        end
        bus.uart_rx = stop;
        wait_clks(CPB);
        bus.uart_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_frame(w[31:24], 1'b1);
        send_frame(w[23:16], 1'b1);
        send_frame(w[15:8], 1'b1);
        send_frame(w[7:0], 1'b1);
`ifdef LOADER_CKSUM_EN
        send_frame(8'(w[31:24] + w[23:16] + w[15:8] + w[7:0]), 1'b1);
`endif
    endtask

    // Reference: words land at consecutive addresses until 0xFF has been written.
    task automatic model_write(input logic [31:0] w);
        if (!m_done) begin
            exp_q.push_back({8'(m_addr), w});
            if (m_addr == 255) begin
                m_done = 1'b1;
                m_addr = 0;
            end else begin
                m_addr++;
            end
        end
    endtask

    task automatic expect_word(input logic [31:0] w);
        send_word(w);
        model_write(w);
    endtask

    task automatic check_writes(input string tag);
        int n;
        wait_clks(3);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.uart_rx = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);
        m_addr = 0;
        m_done = 1'b0;
        obs_q.delete();
        exp_q.delete();
        n_ferr = 0;
        n_cerr = 0;
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({bus.wr_en, bus.busy, bus.done, bus.frame_err, bus.cksum_err,
                    bus.wr_addr, bus.wr_data});
    endfunction

    initial begin
        logic [7:0] b;
        bus.uart_rx = 1'b1;
        rst_n = 1'b0;
        wait_clks(3);
        check("reset_outputs", out_vec(), 64'd0);
        rst_n = 1'b1;
        wait_clks(3);

        // Single word, then a couple of random words.
        expect_word(32'h12345678);
        check_writes("t1");
        check("t1_addr", 64'(bus.wr_addr), 64'h01);
        check("t1_busy", 64'(bus.busy), 64'd0);
        expect_word($urandom);
        expect_word($urandom);
        check_writes("t1_rand");
        check("t1_rand_addr", 64'(bus.wr_addr), 64'h03);

        // Bad stop bit discards the byte, next word still lands at 0x00.
        do_reset();
        send_frame(8'h11, 1'b0);
        wait_clks(2 * CPB);
        expect_word(32'hAABBCCDD);
        check_writes("t3");
        check("t3_frame_err", 64'(n_ferr), 64'd1);

        // Partial word times out after TIMEOUT_BITS bit times of idle.
        do_reset();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        wait_clks(TIMEOUT_BITS * CPB - 20);
        check("t4_busy_held", 64'(bus.busy), 64'd1);
        wait_clks(40);
        check("t4_busy_dropped", 64'(bus.busy), 64'd0);
        wait_clks(400 - TIMEOUT_BITS * CPB - 20);
        check_writes("t4_partial");
        expect_word(32'hDEADBEEF);
        check_writes("t4");
        check("t4_addr", 64'(bus.wr_addr), 64'h01);

        // Short glitch is a false start.
        bus.uart_rx = 1'b0;
        wait_clks(3);
        bus.uart_rx = 1'b1;
        wait_clks(4 * CPB);
        check("t5_glitch_busy", 64'(bus.busy), 64'd0);
        check("t5_glitch_ferr", 64'(n_ferr), 64'd0);
        check_writes("t5_glitch");

        // Reset in the middle of bit 4 of a byte.
        b = 8'($urandom);
        bus.uart_rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.uart_rx = b[i];
            wait_clks(CPB);
        end
        bus.uart_rx = b[4];
        wait_clks(2);
        rst_n = 1'b0;
        bus.uart_rx = 1'b1;
        wait_clks(1);
        check("t5_reset_outputs", out_vec(), 64'd0);
        rst_n = 1'b1;
        wait_clks(3);
        m_addr = 0;
        m_done = 1'b0;
        expect_word($urandom);
        check_writes("t5_after_reset");

        // Full fill of 256 random words, then done locks out writes.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            expect_word($urandom);
        end
        check_writes("t2_fill");
        check("t2_done", 64'(bus.done), 64'd1);
        check("t2_addr_wrap", 64'(bus.wr_addr), 64'h00);
        expect_word($urandom);
        check_writes("t2_after_done");
        check("t2_done_sticky", 64'(bus.done), 64'd1);
        check("t2_busy", 64'(bus.busy), 64'd0);

`ifdef LOADER_CKSUM_EN
        // Good checksum writes, bad checksum pulses cksum_err and writes nothing.
        do_reset();
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        send_frame(8'h04, 1'b1);
        send_frame(8'h0A, 1'b1);
        model_write(32'h01020304);
        check_writes("t6_good");
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        send_frame(8'h04, 1'b1);
        send_frame(8'h0B, 1'b1);
        check_writes("t6_bad");
        check("t6_cksum_err", 64'(n_cerr), 64'd1);
        check("t6_addr", 64'(bus.wr_addr), 64'h01);
        check("t6_busy", 64'(bus.busy), 64'd0);
`else
        check("cksum_err_quiet", 64'(n_cerr), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
